// File: rtl/pe_alu_xbar_pkg.sv
// Shared types and field layout for the PE slice: ALU op encoding, config-chain bit map,
// input-crossbar source encoding.
package pe_alu_xbar_pkg;

  localparam int CFG_W    = 13;
  localparam int OP_W     = 4;
  localparam int OP_LSB   = 9;
  localparam int OSEL_BIT = 8;
  localparam int XSEL_W   = 2;
  localparam int XBAR_N   = 4;
  localparam int XSEL_LSB [XBAR_N] = '{0, 2, 4, 6};

  typedef enum logic [XSEL_W-1:0] {
    SRC_IN0 = 2'd0,
    SRC_IN1 = 2'd1,
    SRC_ALU = 2'd2,
    SRC_BYP = 2'd3
  } src_sel_e;

  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_MUL   = 4'd2,
    OP_AND   = 4'd3,
    OP_OR    = 4'd4,
    OP_XOR   = 4'd5,
    OP_SHL   = 4'd6,
    OP_SHR   = 4'd7,
    OP_ASHR  = 4'd8,
    OP_EQ    = 4'd9,
    OP_LT    = 4'd10,
    OP_LTU   = 4'd11,
    OP_MIN   = 4'd12,
    OP_MAX   = 4'd13,
    OP_PASSA = 4'd14,
    OP_PASSB = 4'd15
  } alu_op_e;

endpackage

// File: rtl/pe_alu.sv
// Combinational two-operand ALU; op 2 multiplies only when PE_ALU_MUL_EN is defined, else yields 0.
// Zero latency (parent registers the result); no backpressure.
module pe_alu
  import pe_alu_xbar_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r
);

  localparam int SH_W = $clog2(WIDTH);

  logic [SH_W-1:0] sh;
  assign sh = b[SH_W-1:0];

  always_comb begin
    r = '0;
    case (op)
      OP_ADD:   r = a + b;
      OP_SUB:   r = a - b;
`ifdef PE_ALU_MUL_EN
      OP_MUL:   r = a * b;
`else
      OP_MUL:   r = '0;
`endif
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_SHL:   r = a << sh;
      OP_SHR:   r = a >> sh;
      OP_ASHR:  r = $signed(a) >>> sh;
      OP_EQ:    r = WIDTH'(a == b);
      OP_LT:    r = WIDTH'($signed(a) < $signed(b));
      OP_LTU:   r = WIDTH'(a < b);
      OP_MIN:   r = ($signed(a) < $signed(b)) ? a : b;
      OP_MAX:   r = ($signed(a) > $signed(b)) ? a : b;
      OP_PASSA: r = a;
      OP_PASSB: r = b;
      default:  r = '0;
    endcase
  end

endmodule

// File: rtl/pe_alu_xbar.sv
// CGRA PE slice: 4x4 input crossbar, registered ALU, 2x1 output crossbar, 13-bit config scan chain (MUL gated by PE_ALU_MUL_EN).
// ALU path 1 clk, bypass path 0 clk; no backpressure, the chain shifts whenever config_en is high.
module pe_alu_xbar
  import pe_alu_xbar_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             config_en,
  input  logic             config_in,
  output logic             config_out,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] byp0,
  output logic [WIDTH-1:0] byp1
);

  logic [CFG_W-1:0] cfg_q, cfg_d;
  logic [WIDTH-1:0] alu_q, alu_d;
  logic [WIDTH-1:0] byp_hold_q, byp_hold_d;
  logic [WIDTH-1:0] xbar [XBAR_N];
  alu_op_e          op;

  assign op = alu_op_e'(cfg_q[OP_LSB +: OP_W]);

  always_comb begin
    cfg_d = cfg_q;
    if (config_en) cfg_d = {cfg_q[CFG_W-2:0], config_in};
  end

  // Feedback sources come only from flops, so no config can close a combinational loop.
  always_comb begin
    for (int k = 0; k < XBAR_N; k++) begin
      xbar[k] = '0;
      case (src_sel_e'(cfg_q[XSEL_LSB[k] +: XSEL_W]))
        SRC_IN0: xbar[k] = in0;
        SRC_IN1: xbar[k] = in1;
        SRC_ALU: xbar[k] = alu_q;
        SRC_BYP: xbar[k] = byp_hold_q;
        default: xbar[k] = '0;
      endcase
    end
  end

  pe_alu #(.WIDTH(WIDTH)) u_alu (
    .op (op),
    .a  (xbar[0]),
    .b  (xbar[1]),
    .r  (alu_d)
  );

  assign byp_hold_d = xbar[2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_q      <= '0;
      alu_q      <= '0;
      byp_hold_q <= '0;
    end else begin
      cfg_q      <= cfg_d;
      alu_q      <= alu_d;
      byp_hold_q <= byp_hold_d;
    end
  end

  assign config_out = cfg_q[CFG_W-1];
  assign out0       = cfg_q[OSEL_BIT] ? xbar[2] : alu_q;
  assign byp0       = xbar[2];
  assign byp1       = xbar[3];

endmodule

// File: tb/tb_pe_alu_xbar.sv
// Directed plus randomized bench for pe_alu_xbar against an arithmetic reference model.
module tb_pe_alu_xbar;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         config_en;
  logic         config_in;
  logic         config_out;
  logic [W-1:0] in0, in1, out0, byp0, byp1;

  int n_checks = 0;
  int n_err    = 0;

  logic [12:0]  m_cfg;
  logic [W-1:0] m_alu, m_hold;

  always #5 clk = ~clk;

  pe_alu_xbar #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .config_en  (config_en),
    .config_in  (config_in),
    .config_out (config_out),
    .in0        (in0),
    .in1        (in1),
    .out0       (out0),
    .byp0       (byp0),
    .byp1       (byp1)
  );

  function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    int              sh = int'(b % 32'd32);
    case (op)
      4'd0:  return W'(ua + ub);
      4'd1:  return W'(ua - ub);
`ifdef PE_ALU_MUL_EN
      4'd2:  return W'(ua * ub);
`else
      4'd2:  return W'(0);
`endif
      4'd3:  return a & b;
      4'd4:  return a | b;
      4'd5:  return a ^ b;
      4'd6:  return W'(ua << sh);
      4'd7:  return W'(ua >> sh);
      4'd8:  return W'(sa >>> sh);
      4'd9:  return (a == b) ? W'(1) : W'(0);
      4'd10: return (sa < sb) ? W'(1) : W'(0);
      4'd11: return (ua < ub) ? W'(1) : W'(0);
      4'd12: return (sa < sb) ? a : b;
      4'd13: return (sa > sb) ? a : b;
      4'd14: return a;
      default: return b;
    endcase
  endfunction

  function automatic logic [W-1:0] m_src(input logic [1:0] s);
    case (s)
      2'd0:    return in0;
      2'd1:    return in1;
      2'd2:    return m_alu;
      default: return m_hold;
    endcase
  endfunction

  function automatic logic [W-1:0] rnd();
    case ($urandom_range(0, 3))
      0:       return W'($urandom_range(0, 40));
      1:       return 32'hFFFF_FFF0 + W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cfg  = '0;
    m_alu  = '0;
    m_hold = '0;
  endtask

  task automatic tick();
    logic [W-1:0] na, nh;
    logic [12:0]  nc;
    na = ref_alu(m_cfg[12:9], m_src(m_cfg[1:0]), m_src(m_cfg[3:2]));
    nh = m_src(m_cfg[5:4]);
    nc = config_en ? {m_cfg[11:0], config_in} : m_cfg;
    @(posedge clk);
    m_alu  = na;
    m_hold = nh;
    m_cfg  = nc;
    #1;
  endtask

  task automatic shift_cfg(input logic [12:0] v);
    config_en = 1'b1;
    for (int i = 12; i >= 0; i--) begin
      config_in = v[i];
      tick();
    end
    config_en = 1'b0;
    config_in = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":out0"}, out0, m_cfg[8] ? m_src(m_cfg[5:4]) : m_alu);
    chk({tag, ":byp0"}, byp0, m_src(m_cfg[5:4]));
    chk({tag, ":byp1"}, byp1, m_src(m_cfg[7:6]));
    chk({tag, ":cfg_out"}, W'(config_out), W'(m_cfg[12]));
  endtask

  initial begin
    logic [12:0] c;
    reset = 1'b0; config_en = 1'b0; config_in = 1'b0;
    in0 = 32'd5; in1 = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out0", out0, 32'd0);
    chk("rst_byp0", byp0, 32'd5);
    chk("rst_byp1", byp1, 32'd5);
    chk("rst_cfg_out", W'(config_out), 32'd0);
    reset = 1'b1;
    #1;
    chk("rel_out0", out0, 32'd0);
    tick();
    chk("rel_add_in0", out0, 32'd10);
    check_all("rel");

    shift_cfg(13'h004);
    in0 = 32'd7; in1 = 32'd9;
    tick();
    chk("add", out0, 32'd16);

    shift_cfg(13'h204);
    in0 = 32'd3; in1 = 32'd5;
    tick();
    chk("sub_wrap", out0, 32'hFFFF_FFFE);

    shift_cfg(13'h404);
    in0 = 32'd6; in1 = 32'd7;
    tick();
`ifdef PE_ALU_MUL_EN
    chk("mul", out0, 32'd42);
`else
    chk("mul_off", out0, 32'd0);
`endif

    reset = 1'b0; #1; model_reset(); reset = 1'b1;
    in0 = 32'd0; in1 = 32'd0;
    shift_cfg(13'h002);
    chk("acc_start", out0, 32'd0);
    in0 = 32'd1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("acc", out0, W'(i));
    end

    reset = 1'b0; #1; model_reset(); reset = 1'b1;
    config_en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      chk("chain_pre", W'(config_out), 32'd0);
      config_in = 1'b1;
      tick();
    end
    for (int i = 0; i < 13; i++) begin
      chk("chain_ones", W'(config_out), 32'd1);
      config_in = 1'b0;
      tick();
    end
    chk("chain_zero", W'(config_out), 32'd0);
    config_en = 1'b0;

    shift_cfg(13'h110);
    in0 = 32'h11; in1 = 32'hAB;
    #1;
    chk("byp_out0", out0, 32'hAB);
    chk("byp_byp0", byp0, 32'hAB);
    in1 = 32'h5A5A;
    #1;
    chk("byp_out0_comb", out0, 32'h5A5A);
    chk("byp_byp0_comb", byp0, 32'h5A5A);
    check_all("byp");

    shift_cfg(13'h1D10);
    in0 = 32'h21; in1 = 32'h77;
    tick();
    tick();
    chk("pre_rst_out0", out0, 32'h77);
    chk("pre_rst_cfg_out", W'(config_out), 32'd1);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_out0", out0, 32'd0);
    chk("mid_rst_byp0", byp0, 32'h21);
    chk("mid_rst_cfg_out", W'(config_out), 32'd0);
    @(posedge clk);
    #1;
    model_reset();
    reset = 1'b1;
    tick();
    chk("resume", out0, 32'h42);
    check_all("resume");

    for (int t = 0; t < 40; t++) begin
      c = 13'($urandom);
      shift_cfg(c);
      for (int j = 0; j < 5; j++) begin
        in0 = rnd();
        in1 = rnd();
        #1;
        check_all("rand");
        tick();
      end
      check_all("rand_end");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/pe_alu_xbar.md
Name: pe_alu_xbar

Overview:
- Configurable CGRA processing-element slice: a 4x4 fully-connected input crossbar, a registered two-operand ALU and a 2x1 output crossbar.
- All configuration is held in one serial scan chain (config_in to config_out) that shifts on the datapath clock.
- Instantiated per tile inside PE blocks; neighbouring tiles chain config_out to config_in.

Parameters:
- WIDTH, 32, datapath width in bits (>=8).

Ports:
- clk  in  1  single clock for datapath and config shifting
- reset  in  1  asynchronous, active-low reset
- config_en  in  1  shift-enable for the config chain
- config_in  in  1  serial config bit in
- config_out  out  1  serial config bit out (chain MSB)
- in0  in  WIDTH  data input 0
- in1  in  WIDTH  data input 1
- out0  out  WIDTH  output-crossbar result
- byp0  out  WIDTH  input-crossbar output 2 (bypass)
- byp1  out  WIDTH  input-crossbar output 3 (bypass)

Behaviour:
- Config register cfg[12:0]; reset (low) clears it to 0 asynchronously.
- On posedge clk with config_en=1: cfg <= {cfg[11:0], config_in}. config_out = cfg[12].
- The first bit shifted lands in cfg[12] after 13 shifts.
- Fields:
  - cfg[12:9] ALU op
  - cfg[8] out sel
  - cfg[7:6] xsel3, cfg[5:4] xsel2, cfg[3:2] xsel1, cfg[1:0] xsel0
- Fields act combinationally and immediately. Datapath results during shifting are don't-care; the bench must not check them.
- Input crossbar (combinational) sources: 0=in0, 1=in1, 2=alu_q, 3=byp-hold.
  - byp-hold is the register holding the previous cycle's xbar out2.
  - xbar outK = source[xselK].
  - ALU operand a = xbar out0; operand b = xbar out1; byp0 = out2; byp1 = out3.
- ALU, combinational result r; alu_q <= r every posedge clk, including while config_en=1. Ops:
  - 0 ADD a+b; 1 SUB a-b; 2 MUL low WIDTH bits of a*b (see feature).
  - 3 AND; 4 OR; 5 XOR.
  - 6 SHL a<<b[log2(WIDTH)-1:0]; 7 SHR logical; 8 ASHR arithmetic.
  - 9 EQ (1 if a==b else 0); 10 LT signed; 11 LTU unsigned.
  - 12 MIN signed; 13 MAX signed; 14 pass a; 15 pass b.
- Arithmetic wraps modulo 2^WIDTH; no flags.
- Output crossbar: out0 = cfg[8] ? xbar out2 : alu_q.
- Latency: in0/in1 to out0 via the ALU is exactly 1 clk. The bypass path is combinational (0 clk).
- Reset values:
  - alu_q=0, byp-hold=0, cfg=0.
  - With cfg=0 everything selects in0, so out0 = alu_q = 0 and byp0 = byp1 = in0 combinationally.
- Reset asserted mid-operation clears alu_q, byp-hold and cfg at once; after release, resume from that all-zero state.
- Feedback paths (alu_q, byp-hold) are registered, so no combinational loop exists for any config.

Optional Feature:
- PE_ALU_MUL_EN.
- Defined: op 2 = low WIDTH bits of unsigned a*b.
- Undefined: no multiplier is inferred and op 2 yields 0.

Decomposition:
- Package pe_alu_xbar_pkg:
  - ALU op enum (4 bits, values above)
  - CFG_W=13
  - field LSB offsets (OP_LSB=9, OSEL_BIT=8, XSEL_LSB[k]=2k)
  - source-select encoding constants.
- One natural sub-module: pe_alu (combinational op decode, WIDTH-parameterised). Crossbars and config chain stay in the top.

Test Plan:
- Reset low, then release with in0=5 → alu_q=0, out0=0, config_out=0, byp0=byp1=5.
- ADD: shift 13 bits op=0, osel=0, xsel0=0, xsel1=1 (MSB-first: 0000_0_00_00_01_00); in0=7, in1=9 → out0=16 one clk later.
- SUB wrap: op=1, in0=3, in1=5, WIDTH=32 → out0=0xFFFFFFFE.
- MUL: op=2, in0=6, in1=7 → out0=42 with PE_ALU_MUL_EN; out0=0 without.
- Accumulate: op=0, xsel0=2 (alu_q), xsel1=0 (in0), in0=1 held for 4 clks from alu_q=0 → out0 sequence 1,2,3,4.
- Chain and bypass:
  - shift 0x1FFF then 13 zeros → config_out outputs 13 ones, then zeros.
  - osel=1, xsel2=1, in1=0xAB → out0=byp0=0xAB combinationally.
  - Reset pulse mid-sequence → cfg and alu_q go to 0 immediately.
